shared_alu_arbiter: RTL

- N-channel round-robin arbiter and operand/result router in front of one shared SHARE_SUPERALU instance.
- Generalises the fixed CPU/SA ALU sharing (a two-way priority mux) to N requesters, with latched operands, fair arbitration and per-channel completion pulses.
- Sits between the ALU and its clients: SERIAL_CPU io path, SA engines, and future tuning loops.

---
 rtl/shared_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/shared_alu_arbiter.sv
// -----------------------------------------------------------------------------
// shared_alu_arbiter
//
// Round-robin arbiter and operand/result router placed in front of a single
// shared ALU. Up to NCH clients request the ALU with a level REQ. The winner's
// operands are latched, the ALU is started, and the result is latched and
// returned with a one-cycle DONE pulse to the owner.
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   REQ[NCH]              per-channel request level
//   REQ_X/REQ_Y           packed operands, channel k at [k*DW +: DW]
//   REQ_TYPE/REQ_MODE     packed alu_type (3b) / mode_type (2b) codes
//   X_IN, Y_IN, ALU_TYPE, MODE_TYPE, ALU_START   towards the ALU
//   FOUT, POUT, ALU_DONE  from the ALU
//   GNT[NCH]              one-hot current owner
//   DONE[NCH]             one-cycle completion pulse to the owner
//   RES_F, RES_P          latched results, held until the next completion
//   BUSY                  arbiter not idle
//   ERR[NCH]              sticky per-channel timeout flag (timeout build only)
//
// Build option: define SHARED_ALU_TIMEOUT_EN to bound the WAIT state with a
// TMO_W-bit counter; on expiry the owner gets ERR, zero results and DONE.
// -----------------------------------------------------------------------------
module shared_alu_arbiter #(
    parameter int NCH   = 2,
    parameter int DW    = 13,
    parameter int GW    = 3,
    parameter int TMO_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NCH-1:0]     REQ,
    input  logic [NCH*DW-1:0]  REQ_X,
    input  logic [NCH*DW-1:0]  REQ_Y,
    input  logic [NCH*3-1:0]   REQ_TYPE,
    input  logic [NCH*2-1:0]   REQ_MODE,
    output logic [DW-1:0]      X_IN,
    output logic [DW-1:0]      Y_IN,
    output logic               ALU_START,
    output logic [2:0]         ALU_TYPE,
    output logic [1:0]         MODE_TYPE,
    input  logic [DW-1:0]      FOUT,
    input  logic [DW-1:0]      POUT,
    input  logic               ALU_DONE,
    output logic [NCH-1:0]     GNT,
    output logic [NCH-1:0]     DONE,
    output logic [DW-1:0]      RES_F,
    output logic [DW-1:0]      RES_P,
    output logic               BUSY
`ifdef SHARED_ALU_TIMEOUT_EN
    ,
    output logic [NCH-1:0]     ERR
`endif
);

    // Channel slots are padded to 2**GW so any GW-bit index is in range.
    localparam int NSLOT = 1 << GW;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    generate
        if (NCH < 2 || NCH > 8 || NSLOT < NCH || TMO_W < 2) begin : g_param_err
            $error("shared_alu_arbiter: illegal NCH/GW/TMO_W combination");
        end
    endgenerate

    state_t          state_q, state_d;
    logic [GW-1:0]   ptr_q, ptr_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic            start_q, start_d;
    logic [DW-1:0]   x_q, x_d, y_q, y_d;
    logic [2:0]      type_q, type_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   res_f_q, res_f_d, res_p_q, res_p_d;
`ifdef SHARED_ALU_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [NCH-1:0]   err_q, err_d;
`endif

    // Unpack the request bus into indexable per-channel slots.
    logic [NSLOT-1:0] req_slot;
    logic [DW-1:0]    x_slot    [NSLOT];
    logic [DW-1:0]    y_slot    [NSLOT];
    logic [2:0]       type_slot [NSLOT];
    logic [1:0]       mode_slot [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NCH) begin : g_used
                assign req_slot[gi]  = REQ[gi];
                assign x_slot[gi]    = REQ_X[gi*DW +: DW];
                assign y_slot[gi]    = REQ_Y[gi*DW +: DW];
                assign type_slot[gi] = REQ_TYPE[gi*3 +: 3];
                assign mode_slot[gi] = REQ_MODE[gi*2 +: 2];
            end else begin : g_pad
                assign req_slot[gi]  = 1'b0;
                assign x_slot[gi]    = '0;
                assign y_slot[gi]    = '0;
                assign type_slot[gi] = '0;
                assign mode_slot[gi] = '0;
            end
        end
    endgenerate

    // Round-robin search: first requester at pointer+1, pointer+2, ... mod NCH.
    // ptr < NCH and i <= NCH, so one conditional subtract wraps correctly.
    logic [GW:0]   cand;
    logic          win_valid;
    logic [GW-1:0] win_idx;

    always_comb begin
        cand      = '0;
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = {1'b0, ptr_q} + (GW+1)'(i);
            if (cand >= (GW+1)'(NCH)) begin
                cand = cand - (GW+1)'(NCH);
            end
            if (!win_valid && req_slot[cand[GW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        start_d = start_q;
        x_d     = x_q;
        y_d     = y_q;
        type_d  = type_q;
        mode_d  = mode_q;
        res_f_d = res_f_q;
        res_p_d = res_p_q;
`ifdef SHARED_ALU_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    x_d     = x_slot[win_idx];
                    y_d     = y_slot[win_idx];
                    type_d  = type_slot[win_idx];
                    mode_d  = mode_slot[win_idx];
                    gnt_d   = NCH'(1) << win_idx;
                    ptr_d   = win_idx;
                    start_d = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
`ifdef SHARED_ALU_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ALU_DONE) begin
                    res_f_d = FOUT;
                    res_p_d = POUT;
                    start_d = 1'b0;
                    state_d = S_RESP;
                end
`ifdef SHARED_ALU_TIMEOUT_EN
                else if (tmo_q == '1) begin
                    // Give up on the ALU: flag the owner but still complete.
                    err_d   = err_q | gnt_q;
                    res_f_d = '0;
                    res_p_d = '0;
                    start_d = 1'b0;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_RESP: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            ptr_q   <= GW'(NCH - 1);
            gnt_q   <= '0;
            start_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            type_q  <= '0;
            mode_q  <= '0;
            res_f_q <= '0;
            res_p_q <= '0;
`ifdef SHARED_ALU_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            start_q <= start_d;
            x_q     <= x_d;
            y_q     <= y_d;
            type_q  <= type_d;
            mode_q  <= mode_d;
            res_f_q <= res_f_d;
            res_p_q <= res_p_d;
`ifdef SHARED_ALU_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    assign X_IN      = x_q;
    assign Y_IN      = y_q;
    assign ALU_TYPE  = type_q;
    assign MODE_TYPE = mode_q;
    assign ALU_START = start_q;
    assign GNT       = gnt_q;
    // DONE is the grant qualified by the single RESP cycle.
    assign DONE      = gnt_q & {NCH{state_q == S_RESP}};
    assign RES_F     = res_f_q;
    assign RES_P     = res_p_q;
    assign BUSY      = (state_q != S_IDLE);
`ifdef SHARED_ALU_TIMEOUT_EN
    assign ERR       = err_q;
`endif

endmodule
